// File: rtl/ks_round_key_sequencer_if.sv
// Bundle between a key source, the round-key sequencer and a round engine.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both high. A producer holding valid high
// keeps its payload stable until that transfer. load_valid/load_ready moves
// key_in + mode_in into the sequencer; rk_valid/rk_ready moves rk_out,
// rk_round and rk_last to the round engine. start is a one-cycle request
// and has no ready; the sequencer ignores it when it cannot honour it.
interface ks_round_key_sequencer_if;
    logic [64:1] key_in;
    logic        mode_in;
    logic        load_valid;
    logic        load_ready;
    logic        start;
    logic [48:1] rk_out;
    logic [4:0]  rk_round;
    logic        rk_valid;
    logic        rk_ready;
    logic        rk_last;
    logic        done;
    logic        key_loaded;

    modport master (
        output key_in, mode_in, load_valid, start, rk_ready,
        input  load_ready, rk_out, rk_round, rk_valid, rk_last, done, key_loaded
    );

    modport slave (
        input  key_in, mode_in, load_valid, start, rk_ready,
        output load_ready, rk_out, rk_round, rk_valid, rk_last, done, key_loaded
    );
endinterface

// File: rtl/ks_round_key_sequencer.sv
// DES round-key sequencer: expands a 64-bit key into its 16 round keys once,
// keeps them in a register bank, and streams them K1..K16 (encrypt) or
// K16..K1 (decrypt) over a valid/ready channel.

// Pure combinational DES key schedule (PC-1, cumulative rotations, PC-2).
// Bit numbering follows DES: bit 1 is the MSB, so DES bit b of the key is
// key_in[65-b] and bit b of a round key lands at round_keys[r][48-b].
module ks_key_schedule (
    input  logic [64:1]       key_in,
    output logic [15:0][47:0] round_keys
);
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // C/D halves after each round; index 0 is the PC-1 output. The MSB of
    // each 28-bit half is DES position 1 of that half.
    logic [27:0] c_s [17];
    logic [27:0] d_s [17];
    logic [55:0] cd0;

    // Parity bits never reach PC-1, and the last rotation returns C/D to
    // their start value, so these are folded away on purpose.
    logic unused_parity_bits;
    logic unused_final_cd;

    assign unused_parity_bits = ^{key_in[57], key_in[49], key_in[41], key_in[33],
                                  key_in[25], key_in[17], key_in[9],  key_in[1]};
    assign unused_final_cd    = ^{c_s[16], d_s[16]};

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign cd0[55-g] = key_in[65-PC1[g]];
    end

    assign c_s[0] = cd0[55:28];
    assign d_s[0] = cd0[27:0];

    for (genvar r = 0; r < 16; r++) begin : g_round
        if (SHIFTS[r] == 1) begin : g_rot1
            assign c_s[r+1] = {c_s[r][26:0], c_s[r][27]};
            assign d_s[r+1] = {d_s[r][26:0], d_s[r][27]};
        end else begin : g_rot2
            assign c_s[r+1] = {c_s[r][25:0], c_s[r][27:26]};
            assign d_s[r+1] = {d_s[r][25:0], d_s[r][27:26]};
        end

        for (genvar j = 0; j < 48; j++) begin : g_pc2
            if (PC2[j] <= 28) begin : g_from_c
                assign round_keys[r][47-j] = c_s[r+1][28-PC2[j]];
            end else begin : g_from_d
                assign round_keys[r][47-j] = d_s[r+1][56-PC2[j]];
            end
        end
    end
endmodule

module ks_round_key_sequencer (
    input  logic                    clk,
    input  logic                    rst,
    ks_round_key_sequencer_if.slave bus,
    output logic                    dbg_state
);
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctr_q, ctr_d;
    logic             mode_q, mode_d;
    logic [15:0][47:0] bank_q, bank_d;
    logic             key_loaded_q, key_loaded_d;
    logic             done_q, done_d;

    logic [15:0][47:0] sched_keys;
    logic             load_fire;
    logic             start_fire;
    logic [3:0]       rk_idx;

    ks_key_schedule u_ks (
        .key_in     (bus.key_in),
        .round_keys (sched_keys)
    );

    // Loads are only taken between sequences and never while reset is held.
    assign bus.load_ready = (state_q == IDLE) && !rst;
    assign bus.done       = done_q;
    assign bus.key_loaded = key_loaded_q;
    assign dbg_state      = state_q;

    // A load takes priority over a replay request in the same cycle.
    assign load_fire  = bus.load_valid && bus.load_ready;
    assign start_fire = (state_q == IDLE) && bus.start && key_loaded_q && !bus.load_valid;

    // Next-state: accept a load or replay in IDLE, walk the counter in STREAM.
    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        mode_d       = mode_q;
        bank_d       = bank_q;
        key_loaded_d = key_loaded_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    bank_d       = sched_keys;
                    mode_d       = bus.mode_in;
                    key_loaded_d = 1'b1;
                    ctr_d        = 4'd0;
                    state_d      = STREAM;
                end else if (start_fire) begin
                    mode_d  = bus.mode_in;
                    ctr_d   = 4'd0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.rk_ready) begin
                    if (ctr_q == 4'd15) begin
                        ctr_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ctr_d = ctr_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: outputs depend only on registered state, so a stall
    // (valid without ready) leaves them untouched.
    always_comb begin
        rk_idx       = mode_q ? (4'd15 - ctr_q) : ctr_q;
        bus.rk_valid = 1'b0;
        bus.rk_last  = 1'b0;
        bus.rk_round = 5'd0;
        bus.rk_out   = '0;
        if (state_q == STREAM) begin
            bus.rk_valid = 1'b1;
            bus.rk_last  = (ctr_q == 4'd15);
            bus.rk_round = {1'b0, ctr_q} + 5'd1;
            bus.rk_out   = bank_q[rk_idx];
        end
    end

    // State register with synchronous reset; reset also forgets the key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ctr_q        <= 4'd0;
            mode_q       <= 1'b0;
            bank_q       <= '0;
            key_loaded_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            mode_q       <= mode_d;
            bank_q       <= bank_d;
            key_loaded_q <= key_loaded_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_ks_round_key_sequencer.sv
// Bench for ks_round_key_sequencer: drivers push expected round keys into a
// queue when a load/start is accepted; a negedge monitor pops and compares on
// every rk handshake and checks stall stability, idle outputs and done.
module tb_ks_round_key_sequencer;
    localparam int W = 54;  // {rk_last, rk_round[4:0], rk_out[47:0]}

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] TEST_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] TEST_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] TEST_K16 = 48'hCB3D8B0E17F5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic dbg_state;

    always #5 clk = ~clk;

    ks_round_key_sequencer_if bus ();

    ks_round_key_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q [$];
    int            ready_pct = 100;
    int            hs_count = 0;
    bit            mon_en = 1'b0;
    logic [63:0]   mdl_key = '0;
    bit            mdl_loaded = 1'b0;

    // ---------------- reference model ----------------
    // Round key n computed directly: PC-1, then rotate each half by the
    // cumulative shift total of rounds 1..n, then PC-2.
    function automatic logic [47:0] ref_round_key(input logic [63:0] key, input int rnd);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        int rot;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        rot = 0;
        for (int i = 0; i < rnd; i++) rot += SHIFTS[i];
        rot = rot % 28;
        c = (c << rot) | (c >> (28 - rot));
        d = (d << rot) | (d >> (28 - rot));
        cd = {c, d};
        for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2[j]];
        return k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [63:0] key, input logic mode);
        for (int i = 0; i < 16; i++) begin
            int rnd;
            rnd = mode ? (16 - i) : (i + 1);
            exp_q.push_back({(i == 15), 5'(i + 1), ref_round_key(key, rnd)});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] key, input logic mode, input logic with_start,
                           output logic done_seen);
        bit accepted;
        int cyc;
        accepted       = 1'b0;
        cyc            = 0;
        done_seen      = 1'b0;
        bus.key_in     = key;
        bus.mode_in    = mode;
        bus.load_valid = 1'b1;
        bus.start      = with_start;
        while (!accepted && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.load_ready) begin
                accepted  = 1'b1;
                done_seen = bus.done;
            end
        end
        tick();
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        if (accepted) begin
            mdl_key    = key;
            mdl_loaded = 1'b1;
            push_stream(key, mode);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: load_ready stayed 0 for %0d cycles, expected 1", cyc);
        end
    endtask

    // Caller guarantees the sequencer is idle.
    task automatic do_start(input logic mode);
        bus.start   = 1'b1;
        bus.mode_in = mode;
        tick();
        bus.start   = 1'b0;
        if (mdl_loaded) push_stream(mdl_key, mode);
    endtask

    // Returns just after the final handshake edge, with the DUT back in idle.
    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d keys outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    // ---------------- rk_ready driver ----------------
    initial begin
        bus.rk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rk_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ---------------- monitor ----------------
    logic          done_exp = 1'b0;
    bit            stall_prev = 1'b0;
    logic [W:0]    prev_vec = '0;
    logic [W-1:0]  e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                done_exp   = 1'b0;
                stall_prev = 1'b0;
            end else begin
                check("done", 64'(bus.done), 64'(done_exp));
                done_exp = 1'b0;
                check("load_ready", 64'(bus.load_ready), 64'(!bus.rk_valid));
                if (stall_prev)
                    check("stall_hold", 64'({bus.rk_valid, bus.rk_last, bus.rk_round, bus.rk_out}),
                          64'(prev_vec));
                if (bus.rk_valid) begin
                    if (bus.rk_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL rk_unexpected: got round %0d key %h, expected no key",
                                     bus.rk_round, bus.rk_out);
                        end else begin
                            e = exp_q.pop_front();
                            check("rk", 64'({bus.rk_last, bus.rk_round, bus.rk_out}), 64'(e));
                            done_exp = e[W-1];
                        end
                        hs_count++;
                        stall_prev = 1'b0;
                    end else begin
                        stall_prev = 1'b1;
                        prev_vec   = {bus.rk_valid, bus.rk_last, bus.rk_round, bus.rk_out};
                    end
                end else begin
                    check("idle_out", 64'({bus.rk_last, bus.rk_round, bus.rk_out}), 64'(0));
                    stall_prev = 1'b0;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic        done_seen;
        int          base;
        int          cyc;
        logic [63:0] rkey;

        rst            = 1'b1;
        bus.key_in     = '0;
        bus.mode_in    = 1'b0;
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        repeat (3) tick();

        // Reset values while rst is still held.
        @(negedge clk);
        check("rst_rk_valid",   64'(bus.rk_valid),   64'(0));
        check("rst_rk_round",   64'(bus.rk_round),   64'(0));
        check("rst_rk_out",     64'(bus.rk_out),     64'(0));
        check("rst_rk_last",    64'(bus.rk_last),    64'(0));
        check("rst_done",       64'(bus.done),       64'(0));
        check("rst_key_loaded", 64'(bus.key_loaded), 64'(0));
        check("rst_load_ready", 64'(bus.load_ready), 64'(0));
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Start with no key loaded is ignored.
        ready_pct = 100;
        do_start(1'b0);
        repeat (8) begin
            @(negedge clk);
            check("start_no_key", 64'(bus.rk_valid), 64'(0));
        end
        tick();

        // Known-answer key, encrypt order, ready held high.
        check("model_k1",  64'(ref_round_key(TEST_KEY, 1)),  64'(TEST_K1));
        check("model_k16", 64'(ref_round_key(TEST_KEY, 16)), 64'(TEST_K16));
        do_load(TEST_KEY, 1'b0, 1'b0, done_seen);
        @(negedge clk);
        check("kat_first_valid", 64'(bus.rk_valid), 64'(1));
        check("kat_first_round", 64'(bus.rk_round), 64'(1));
        check("kat_first_key",   64'(bus.rk_out),   64'(TEST_K1));
        check("key_loaded",      64'(bus.key_loaded), 64'(1));
        wait_drain();

        // Replay in decrypt order from the stored bank.
        do_start(1'b1);
        @(negedge clk);
        check("dec_first_key", 64'(bus.rk_out), 64'(TEST_K16));
        wait_drain();

        // Start during a stream is ignored; a load offered mid-stream waits
        // until the done cycle.
        do_start(1'b0);
        repeat (3) tick();
        bus.start   = 1'b1;
        bus.mode_in = 1'b1;
        tick();
        bus.start   = 1'b0;
        rkey = {$urandom(), $urandom()};
        do_load(rkey, 1'b1, 1'b0, done_seen);
        check("load_at_done", 64'(done_seen), 64'(1));
        wait_drain();

        // Load and start together: the load wins, mode taken from the load.
        rkey = {$urandom(), $urandom()};
        do_load(rkey, 1'b0, 1'b1, done_seen);
        wait_drain();

        // Random loads/replays with a 50% ready.
        ready_pct = 50;
        repeat (10) begin
            if ($urandom_range(0, 1) == 1) begin
                rkey = {$urandom(), $urandom()};
                do_load(rkey, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), done_seen);
            end else begin
                do_start(1'($urandom_range(0, 1)));
            end
            wait_drain();
        end

        // Reset right after the 5th handshake of a stream.
        ready_pct = 100;
        repeat (2) tick();
        base = hs_count;
        do_load(TEST_KEY, 1'b0, 1'b0, done_seen);
        cyc = 0;
        while (hs_count < base + 5 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("five_handshakes", 64'(hs_count - base), 64'(5));
        tick();
        rst = 1'b1;
        exp_q.delete();
        mdl_loaded = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_rk_valid",   64'(bus.rk_valid),   64'(0));
        check("abort_rk_round",   64'(bus.rk_round),   64'(0));
        check("abort_rk_out",     64'(bus.rk_out),     64'(0));
        check("abort_rk_last",    64'(bus.rk_last),    64'(0));
        check("abort_done",       64'(bus.done),       64'(0));
        check("abort_key_loaded", 64'(bus.key_loaded), 64'(0));
        tick();
        do_start(1'b0);
        repeat (8) begin
            @(negedge clk);
            check("start_after_rst", 64'(bus.rk_valid), 64'(0));
        end
        tick();

        // Recovery with a fresh load.
        rkey = {$urandom(), $urandom()};
        do_load(rkey, 1'b1, 1'b0, done_seen);
        wait_drain();
        repeat (2) tick();

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
